// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8N1 deserialiser plus 5-byte frame parser (A5 ADDR DHI DLO CSUM) driving PID config registers.
// Optional build macro UART_PARITY_EN switches the byte format to 8E1 with an even-parity check.
module uart_cmd_rx #(
  parameter int          CLKS_PER_BIT = 1085,
  parameter int          TIMEOUT_CLKS = 21700,
  parameter logic [15:0] RST_KP       = 16'h0100,
  parameter logic [15:0] RST_KI       = 16'h0000,
  parameter logic [15:0] RST_KD       = 16'h0000,
  parameter logic [15:0] RST_SETPOINT = 16'd20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        serial_rx,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [15:0] cfg_k_p,
  output logic [15:0] cfg_k_i,
  output logic [15:0] cfg_k_d,
  output logic [15:0] cfg_setpoint,
  output logic [1:0]  cfg_addr,
  output logic        cfg_valid,
  output logic        frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CLKS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} byte_state_e;
`else
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;
`endif
  typedef enum logic [2:0] {P_HDR, P_ADDR, P_DHI, P_DLO, P_CSUM} frame_state_e;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  byte_state_e   bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          bvalid_q, bvalid_d;
  logic          berr_q, berr_d;
`ifdef UART_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  frame_state_e  pst_q, pst_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    dhi_q, dhi_d, dlo_q, dlo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d;
  logic [1:0]    cfg_addr_q, cfg_addr_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic          ferr_q, ferr_d;
  logic          timeout;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    bst_d    = bst_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    bvalid_d = 1'b0;
    berr_d   = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (bst_q)
      B_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (rx_prev_q && !rx_sync_q) bst_d = B_START;
      end
      B_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          bst_d = rx_sync_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      B_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_PARITY_EN
          if (bit_q == 3'd7) bst_d = B_PARITY;
`else
          if (bit_q == 3'd7) bst_d = B_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_PARITY_EN
      B_PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          par_err_d = (rx_sync_q != ^shift_q);
          bst_d     = B_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      B_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          bst_d = B_IDLE;
`ifdef UART_PARITY_EN
          if (rx_sync_q && !par_err_q) begin
`else
          if (rx_sync_q) begin
`endif
            byte_d   = shift_q;
            bvalid_d = 1'b1;
          end else begin
            berr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: bst_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bst_q    <= B_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      bvalid_q <= 1'b0;
      berr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      bst_q    <= bst_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      bvalid_q <= bvalid_d;
      berr_q   <= berr_d;
`ifdef UART_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign timeout = (pst_q != P_HDR) && (tmo_q == TMO_END);

  // Byte error outranks a coincident timeout so the two collapse into one frame_err pulse.
  always_comb begin
    pst_d       = pst_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    tmo_d       = (pst_q == P_HDR) ? '0 : tmo_q + TW'(1);
    kp_d        = kp_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    sp_d        = sp_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_valid_d = 1'b0;
    ferr_d      = 1'b0;
    if (berr_q) begin
      ferr_d = 1'b1;
      pst_d  = P_HDR;
    end else if (bvalid_q) begin
      tmo_d = '0;
      unique case (pst_q)
        P_HDR:  if (byte_q == 8'hA5) pst_d = P_ADDR;
        P_ADDR: begin
          if (|byte_q[7:2]) begin
            ferr_d = 1'b1;
            pst_d  = P_HDR;
          end else begin
            addr_d = byte_q[1:0];
            pst_d  = P_DHI;
          end
        end
        P_DHI: begin
          dhi_d = byte_q;
          pst_d = P_DLO;
        end
        P_DLO: begin
          dlo_d = byte_q;
          pst_d = P_CSUM;
        end
        P_CSUM: begin
          pst_d = P_HDR;
          if (byte_q == ({6'b0, addr_q} ^ dhi_q ^ dlo_q)) begin
            cfg_addr_d  = addr_q;
            cfg_valid_d = 1'b1;
            unique case (addr_q)
              2'd0: kp_d = {dhi_q, dlo_q};
              2'd1: ki_d = {dhi_q, dlo_q};
              2'd2: kd_d = {dhi_q, dlo_q};
              2'd3: sp_d = {dhi_q, dlo_q};
              default: ;
            endcase
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: pst_d = P_HDR;
      endcase
    end else if (timeout) begin
      ferr_d = 1'b1;
      pst_d  = P_HDR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pst_q       <= P_HDR;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      tmo_q       <= '0;
      kp_q        <= RST_KP;
      ki_q        <= RST_KI;
      kd_q        <= RST_KD;
      sp_q        <= RST_SETPOINT;
      cfg_addr_q  <= '0;
      cfg_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      pst_q       <= pst_d;
      addr_q      <= addr_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      tmo_q       <= tmo_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      sp_q        <= sp_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_valid_q <= cfg_valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_byte       = byte_q;
  assign rx_byte_valid = bvalid_q;
  assign cfg_k_p       = kp_q;
  assign cfg_k_i       = ki_q;
  assign cfg_k_d       = kd_q;
  assign cfg_setpoint  = sp_q;
  assign cfg_addr      = cfg_addr_q;
  assign cfg_valid     = cfg_valid_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed command frames, then randomized frames checked against a byte-list frame model.
// Define UART_PARITY_EN for both bench and RTL to exercise the 8E1 build.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int TMO = 400;
  localparam logic [15:0] R_KP = 16'h0100, R_KI = 16'h0000, R_KD = 16'h0000, R_SP = 16'd20;

  logic clk = 1'b0, reset_n = 1'b0, serial_rx = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid, cfg_valid, frame_err;
  logic [15:0] cfg_k_p, cfg_k_i, cfg_k_d, cfg_setpoint;
  logic [1:0]  cfg_addr;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO),
    .RST_KP(R_KP), .RST_KI(R_KI), .RST_KD(R_KD), .RST_SETPOINT(R_SP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .serial_rx(serial_rx),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .cfg_k_p(cfg_k_p), .cfg_k_i(cfg_k_i), .cfg_k_d(cfg_k_d), .cfg_setpoint(cfg_setpoint),
    .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] kp, ki, kd, sp;
  } cfg_exp_t;

  int n_checks = 0, n_fail = 0;
  int rxv_cnt = 0, cfgv_cnt = 0, ferr_cnt = 0;
  logic [7:0] exp_byte_q[$];
  cfg_exp_t   exp_cfg_q[$];
  bit         exp_err_q[$];
  logic [15:0] m_regs[4];
  logic [7:0]  m_frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_reset();
    m_regs[0] = R_KP; m_regs[1] = R_KI; m_regs[2] = R_KD; m_regs[3] = R_SP;
    m_frame.delete();
  endfunction

  // Frame model: collect bytes after a header, judge the frame once it is complete.
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] a, h, l, c;
    cfg_exp_t e;
    if (m_frame.size() == 0) begin
      if (b == 8'hA5) m_frame.push_back(b);
      return;
    end
    m_frame.push_back(b);
    if (m_frame.size() == 2 && b > 8'd3) begin
      exp_err_q.push_back(1'b1);
      m_frame.delete();
    end else if (m_frame.size() == 5) begin
      a = m_frame[1]; h = m_frame[2]; l = m_frame[3]; c = m_frame[4];
      if (c == (a ^ h ^ l)) begin
        m_regs[a[1:0]] = {h, l};
        e.addr = a[1:0];
        e.kp = m_regs[0]; e.ki = m_regs[1]; e.kd = m_regs[2]; e.sp = m_regs[3];
        exp_cfg_q.push_back(e);
      end else begin
        exp_err_q.push_back(1'b1);
      end
      m_frame.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int gap);
    if (stop_ok && par_ok) begin
      exp_byte_q.push_back(b);
      model_byte(b);
    end else begin
      exp_err_q.push_back(1'b1);
      m_frame.delete();
    end
    serial_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      wait_cyc(CPB);
    end
`ifdef UART_PARITY_EN
    serial_rx = par_ok ? ^b : ~^b;
    wait_cyc(CPB);
`endif
    serial_rx = stop_ok;
    wait_cyc(CPB);
    serial_rx = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1, 1'b1, $urandom_range(2, 3 * CPB));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
    send_good(8'hA5); send_good(a); send_good(h); send_good(l); send_good(c);
    wait_cyc(2 * CPB);
  endtask

  task automatic long_idle();
    if (m_frame.size() != 0) begin
      exp_err_q.push_back(1'b1);
      m_frame.delete();
    end
    wait_cyc(2 * TMO);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_byte_valid) begin
        rxv_cnt++;
        if (exp_byte_q.size() == 0) check("rx_byte_valid_unexpected", rx_byte_valid, 1'b0);
        else check("rx_byte", rx_byte, exp_byte_q.pop_front());
      end
      if (cfg_valid) begin
        cfgv_cnt++;
        if (exp_cfg_q.size() == 0) check("cfg_valid_unexpected", cfg_valid, 1'b0);
        else begin
          cfg_exp_t e;
          e = exp_cfg_q.pop_front();
          check("cfg_addr", cfg_addr, e.addr);
          check("cfg_k_p", cfg_k_p, e.kp);
          check("cfg_k_i", cfg_k_i, e.ki);
          check("cfg_k_d", cfg_k_d, e.kd);
          check("cfg_setpoint", cfg_setpoint, e.sp);
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        if (exp_err_q.size() == 0) check("frame_err_unexpected", frame_err, 1'b0);
        else void'(exp_err_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, r0;
    model_reset();
    wait_cyc(5);
    reset_n = 1'b1;

    wait_cyc(1000);
    check("reset_k_p", cfg_k_p, 16'h0100);
    check("reset_k_i", cfg_k_i, 16'h0000);
    check("reset_k_d", cfg_k_d, 16'h0000);
    check("reset_setpoint", cfg_setpoint, 16'd20);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_cfg_addr", cfg_addr, 2'd0);
    check("reset_pulse_count", rxv_cnt + cfgv_cnt + ferr_cnt, 0);

    c0 = cfgv_cnt; e0 = ferr_cnt;
    send_frame(8'h00, 8'h12, 8'h34, 8'h26);
    check("t2_k_p", cfg_k_p, 16'h1234);
    check("t2_cfg_addr", cfg_addr, 2'd0);
    check("t2_cfg_valid_pulses", cfgv_cnt - c0, 1);
    check("t2_frame_err_pulses", ferr_cnt - e0, 0);

    send_frame(8'h03, 8'h00, 8'h1E, 8'h1D);
    check("t3_setpoint", cfg_setpoint, 16'd30);
    check("t3_cfg_addr", cfg_addr, 2'd3);
    check("t3_k_p_held", cfg_k_p, 16'h1234);

    c0 = cfgv_cnt; e0 = ferr_cnt;
    send_frame(8'h01, 8'h00, 8'h05, 8'h00);
    check("t4_frame_err_pulses", ferr_cnt - e0, 1);
    check("t4_cfg_valid_pulses", cfgv_cnt - c0, 0);
    check("t4_k_i_held", cfg_k_i, 16'h0000);

    e0 = ferr_cnt;
    send_good(8'hA5); send_good(8'h02);
    long_idle();
    check("t5_timeout_err", ferr_cnt - e0, 1);
    send_frame(8'h02, 8'h00, 8'h07, 8'h05);
    check("t5_k_d", cfg_k_d, 16'h0007);

    r0 = rxv_cnt; e0 = ferr_cnt;
    serial_rx = 1'b0;
    wait_cyc(CPB / 4);
    serial_rx = 1'b1;
    wait_cyc(4 * CPB);
    check("t6_glitch_no_byte", rxv_cnt - r0, 0);
    check("t6_glitch_no_err", ferr_cnt - e0, 0);
    send_byte(8'h55, 1'b0, 1'b1, 2 * CPB);
    check("t6_stop_err", ferr_cnt - e0, 1);
    check("t6_stop_no_byte", rxv_cnt - r0, 0);
`ifdef UART_PARITY_EN
    send_byte(8'h01, 1'b1, 1'b0, 2 * CPB);
    check("t6_parity_err", ferr_cnt - e0, 2);
    check("t6_parity_no_byte", rxv_cnt - r0, 0);
`endif

    // Mid-frame reset discards the partial frame and restores register defaults.
    send_good(8'hA5); send_good(8'h02);
    reset_n = 1'b0;
    wait_cyc(3);
    model_reset();
    reset_n = 1'b1;
    wait_cyc(2);
    check("rst_k_p", cfg_k_p, 16'h0100);
    check("rst_k_d", cfg_k_d, 16'h0000);
    check("rst_setpoint", cfg_setpoint, 16'd20);
    send_frame(8'h01, 8'h00, 8'h09, 8'h08);
    check("rst_then_k_i", cfg_k_i, 16'h0009);

    for (int it = 0; it < 25; it++) begin
      logic [7:0] a, h, l, c;
      int kind;
      kind = $urandom_range(0, 5);
      a = 8'($urandom_range(0, 3));
      h = 8'($urandom);
      l = 8'($urandom);
      c = a ^ h ^ l;
      case (kind)
        0, 1: send_frame(a, h, l, c);
        2:    send_frame(a, h, l, c ^ 8'($urandom_range(1, 255)));
        3: begin
          send_good(8'hA5);
          send_good(8'($urandom_range(4, 255)));
          wait_cyc(2 * CPB);
        end
        4: begin
          logic [7:0] j;
          j = 8'($urandom);
          if (j == 8'hA5) j = 8'h5A;
          send_good(j);
          send_frame(a, h, l, c);
        end
        default: begin
          int k;
          k = $urandom_range(1, 3);
          send_good(8'hA5);
          send_good(a);
          if (k > 1) send_good(h);
          if (k > 2) send_good(l);
          if ($urandom_range(0, 1) == 0) long_idle();
          else send_byte(8'($urandom), 1'b0, 1'b1, 2 * CPB);
        end
      endcase
    end

    wait_cyc(4 * CPB);
    check("pending_rx_bytes", exp_byte_q.size(), 0);
    check("pending_cfg_writes", exp_cfg_q.size(), 0);
    check("pending_frame_errs", exp_err_q.size(), 0);
    check("final_k_p", cfg_k_p, m_regs[0]);
    check("final_k_i", cfg_k_i, m_regs[1]);
    check("final_k_d", cfg_k_d, m_regs[2]);
    check("final_setpoint", cfg_setpoint, m_regs[3]);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
